conv_line_buffer: RTL and testbench
===================================

Name: conv_line_buffer

Overview:
- Upstream feeder for the single-channel 3x3 convolution row stage.
- Accepts a raster pixel stream, one pixel per handshake, and assembles rows in a fill buffer.
- Presents three consecutive full rows (image0 oldest, image2 newest) with image_valid held stable until the conv stage signals completion.
- Forces at least one image_valid-low cycle between windows so the conv stage re-arms its internal counter.

Parameters:
DATA_WIDTH, 32, bits per pixel
W, 64, pixels per row
H, 64, rows per frame
F, 3, filter height; fixed at 3, the number of rows presented
ROW_BITS, $clog2(H), width of row indices

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pixel_in  input  DATA_WIDTH  incoming pixel, raster order
pixel_valid  input  1  pixel_in valid
pixel_ready  output  1  buffer can accept pixel; transfer when valid and ready
image0  output  W*DATA_WIDTH  window row n; [0:...] ordering, pixel 0 in slice [0:DATA_WIDTH-1]
image1  output  W*DATA_WIDTH  window row n+1
image2  output  W*DATA_WIDTH  window row n+2
image_valid  output  1  image0..2 hold a complete window
conv_done  input  1  one-cycle pulse from conv stage (its o_valid); current window consumed
window_row  output  ROW_BITS  index n of the top row of the presented window
frame_done  output  1  one-cycle pulse after the last window of a frame is consumed

Behaviour:
- Reset (reset=0, async) clears:
  - all outputs to 0, except pixel_ready, which is 0 during reset and 1 in the first cycle after release;
  - row registers r0, r1, r2 and fill buffer fb;
  - col, in_row, loaded, state=LOAD.
- Fill path:
  - pixel_ready = !fb_full.
  - On handshake, fb[col] <= pixel_in and col++.
  - At col==W-1: col<=0, fb_full<=1, in_row++ (wraps H-1 -> 0).
  - Fill runs independently of state, so the next row can be prefetched while a window is presented.
- Rotate operation (single cycle):
  - r0<=r1, r1<=r2, r2<=fb, fb_full<=0.
  - pixel_ready returns high the cycle after a rotate.
  - fb_full and a pixel handshake are never simultaneous, so there is no write/rotate conflict.
- LOAD state:
  - Each cycle with fb_full: rotate, loaded++.
  - When loaded reaches 3 (on that rotate): state<=PRESENT, window_row<=0, loaded<=0.
- PRESENT state:
  - image_valid=1; image0..2 and window_row stable.
  - On conv_done with window_row==H-F: frame_done pulses 1 cycle, window_row<=0, state<=LOAD.
  - On other conv_done: state<=GAP.
  - Both paths drop image_valid on the next cycle.
- GAP state:
  - image_valid=0.
  - If fb_full: rotate, window_row++, state<=PRESENT; image_valid is high the following cycle.
  - Else wait; GAP lasts at least 1 cycle with no upper bound.
- conv_done outside PRESENT is ignored.
- Latency:
  - Rotate of the third row is in the cycle after the last pixel handshake (the cycle fb_full=1).
  - image_valid is high on the cycle after that rotate.
  - Minimum image_valid-low gap between windows is 1 cycle.
- Frame boundary: rows prefetched into fb during the last window belong to the next frame and are consumed by LOAD; stale r0..r2 are shifted out.
- All outputs are registered; no combinational path from conv_done to image0..2.

Decomposition:
- Package conv_lb_pkg holds:
  - state enum {LOAD, PRESENT, GAP};
  - localparams ROW_W = W*DATA_WIDTH and COL_BITS = $clog2(W).
- Sub-module conv_row_fill: col counter, fb storage, fb_full, pixel_ready, in_row; driven by a rotate strobe from the parent.
- Parent holds the FSM, r0..r2, window_row and frame_done.

Test Plan:
Bench config: W=4, H=5, DATA_WIDTH=8; pixel value = row*16+col.
1. Hold reset=0 with random inputs -> image_valid=0, image0..2=0, window_row=0, frame_done=0, pixel_ready=0. After release, pixel_ready=1 next cycle.
2. Stream 12 pixels back-to-back, conv_done=0 -> image_valid=1 two cycles after the last handshake, with:
   - image0=00_01_02_03, image1=10_11_12_13, image2=20_21_22_23
   - window_row=0
   - state held indefinitely.
3. From step 2, stream row 3 -> pixel_ready=0 after 4 pixels. Then pulse conv_done -> image_valid=0 for exactly 1 cycle, then 1 with:
   - image0=10..13, image2=30..33
   - window_row=1
   - pixel_ready=1.
4. conv_done with fb empty -> image_valid stays 0. Deliver row 4 one pixel every 3 cycles -> image_valid rises 2 cycles after the last handshake; window_row=2.
5. On window_row=2 (H-F), pulse conv_done -> frame_done=1 for one cycle, image_valid=0, window_row=0. Three new rows are needed before image_valid reasserts with image0 = next-frame row 0.
6. Assert reset mid-PRESENT with fb half full -> all outputs 0 asynchronously (same cycle, before next clk edge). Resume stream -> full 3-row LOAD required.

Source files
------------

// File: rtl/conv_lb_pkg.sv
// Shared types and default geometry for the convolution line buffer.
package conv_lb_pkg;

  typedef enum logic [1:0] {LOAD, PRESENT, GAP} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_W          = 64;
  localparam int DEF_H          = 64;
  localparam int ROW_W          = DEF_W * DEF_DATA_WIDTH;
  localparam int COL_BITS       = $clog2(DEF_W);

endpackage

// File: rtl/conv_row_fill.sv
// Row fill buffer: collects one raster row of pixels and holds it until the
// parent rotates it into the window registers.
module conv_row_fill
  import conv_lb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W          = DEF_W,
  parameter int H          = DEF_H,
  parameter int RW         = ROW_W,
  parameter int CB         = COL_BITS,
  parameter int RB         = $clog2(DEF_H)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  rotate,
  output logic                  pixel_ready,
  output logic [0:RW-1]         fb,
  output logic                  fb_full
);

  logic [CB-1:0] col;
  logic [RB-1:0] in_row;
  logic          hs;
  logic          last_col;
  logic          fb_full_nx;

  assign hs       = pixel_valid && pixel_ready;
  assign last_col = (col == CB'(W - 1));

  // A handshake can only happen while fb is empty, so rotate and write never collide.
  always_comb begin
    fb_full_nx = fb_full;
    if (rotate)
      fb_full_nx = 1'b0;
    else if (hs && last_col)
      fb_full_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col         <= '0;
      in_row      <= '0;
      fb          <= '0;
      fb_full     <= 1'b0;
      pixel_ready <= 1'b0;
    end else begin
      fb_full     <= fb_full_nx;
      pixel_ready <= !fb_full_nx;
      if (hs) begin
        fb[col*DATA_WIDTH +: DATA_WIDTH] <= pixel_in;
        if (last_col) begin
          col    <= '0;
          in_row <= (in_row == RB'(H - 1)) ? '0 : in_row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_line_buffer.sv
// Three-row window feeder for the 3x3 conv row stage: rotates filled rows
// through r0..r2 and holds each window until the conv stage consumes it.
module conv_line_buffer
  import conv_lb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W          = DEF_W,
  parameter int H          = DEF_H,
  parameter int F          = 3,
  parameter int ROW_BITS   = $clog2(H)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  output logic [0:W*DATA_WIDTH-1] image0,
  output logic [0:W*DATA_WIDTH-1] image1,
  output logic [0:W*DATA_WIDTH-1] image2,
  output logic                    image_valid,
  input  logic                    conv_done,
  output logic [ROW_BITS-1:0]     window_row,
  output logic                    frame_done
);

  localparam int RW = W * DATA_WIDTH;
  localparam int CB = $clog2(W);

  state_t        state;
  logic [1:0]    loaded;
  logic          rotate;
  logic          fb_full;
  logic [0:RW-1] fb;

  // Rows are only pulled in while no window is being presented.
  assign rotate = fb_full && (state != PRESENT);

  conv_row_fill #(
    .DATA_WIDTH (DATA_WIDTH),
    .W          (W),
    .H          (H),
    .RW         (RW),
    .CB         (CB),
    .RB         (ROW_BITS)
  ) u_fill (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .rotate      (rotate),
    .pixel_ready (pixel_ready),
    .fb          (fb),
    .fb_full     (fb_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      loaded      <= '0;
      image0      <= '0;
      image1      <= '0;
      image2      <= '0;
      image_valid <= 1'b0;
      window_row  <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rotate) begin
        image0 <= image1;
        image1 <= image2;
        image2 <= fb;
      end
      case (state)
        LOAD: begin
          if (fb_full) begin
            if (loaded == 2'(F - 1)) begin
              loaded      <= '0;
              window_row  <= '0;
              image_valid <= 1'b1;
              state       <= PRESENT;
            end else begin
              loaded <= loaded + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (conv_done) begin
            image_valid <= 1'b0;
            if (window_row == ROW_BITS'(H - F)) begin
              frame_done <= 1'b1;
              window_row <= '0;
              state      <= LOAD;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // Staying here at least one cycle gives the conv stage its valid-low re-arm.
          if (fb_full) begin
            window_row  <= window_row + 1'b1;
            image_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer at W=4, H=5, DATA_WIDTH=8; pixel = row*16+col.
module tb_conv_line_buffer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 5;
  localparam int RB = $clog2(H);
  localparam int RW = W * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          conv_done = 1'b0;
  logic          pixel_ready;
  logic [0:RW-1] image0, image1, image2;
  logic          image_valid;
  logic [RB-1:0] window_row;
  logic          frame_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  conv_line_buffer #(
    .DATA_WIDTH (DW),
    .W          (W),
    .H          (H),
    .F          (3),
    .ROW_BITS   (RB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .image0      (image0),
    .image1      (image1),
    .image2      (image2),
    .image_valid (image_valid),
    .conv_done   (conv_done),
    .window_row  (window_row),
    .frame_done  (frame_done)
  );

  typedef struct {
    int          st;
    logic        pv;
    logic [7:0]  pix;
    logic        cd;
    logic        er;
    logic        ev;
    logic        efd;
    logic [2:0]  erow;
    logic        ci;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rv(input int r);
    logic [31:0] x;
    for (int c = 0; c < W; c++) x[31-8*c -: 8] = 8'(r*16 + c);
    return x;
  endfunction

  function automatic void add(input int st, input logic pv, input logic [7:0] pix, input logic cd,
                              input logic er, input logic ev, input logic efd, input logic [2:0] erow,
                              input logic ci, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2);
    vec_t v;
    v.st = st; v.pv = pv; v.pix = pix; v.cd = cd;
    v.er = er; v.ev = ev; v.efd = efd; v.erow = erow;
    v.ci = ci; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    vq.push_back(v);
  endfunction

  // Four back-to-back pixels of row r, then the cycle in which the full row is rotated.
  function automatic void add_row(input int st, input int r, input logic evb, input logic eva,
                                  input logic [2:0] row, input logic [31:0] e0,
                                  input logic [31:0] e1, input logic [31:0] e2);
    for (int c = 0; c < W; c++)
      add(st, 1'b1, 8'(r*16 + c), 1'b0, (c < W-1), evb, 1'b0, row, 1'b0, '0, '0, '0);
    add(st, 1'b0, 8'h00, 1'b0, 1'b1, eva, 1'b0, row, 1'b1, e0, e1, e2);
  endfunction

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      pixel_valid = vq[i].pv;
      pixel_in    = vq[i].pix;
      conv_done   = vq[i].cd;
      @(posedge clk);
      #1;
      chk($sformatf("s%0d.v%0d.pixel_ready", vq[i].st, i), 32'(pixel_ready), 32'(vq[i].er));
      chk($sformatf("s%0d.v%0d.image_valid", vq[i].st, i), 32'(image_valid), 32'(vq[i].ev));
      chk($sformatf("s%0d.v%0d.frame_done", vq[i].st, i), 32'(frame_done), 32'(vq[i].efd));
      chk($sformatf("s%0d.v%0d.window_row", vq[i].st, i), 32'(window_row), 32'(vq[i].erow));
      if (vq[i].ci) begin
        chk($sformatf("s%0d.v%0d.image0", vq[i].st, i), image0, vq[i].e0);
        chk($sformatf("s%0d.v%0d.image1", vq[i].st, i), image1, vq[i].e1);
        chk($sformatf("s%0d.v%0d.image2", vq[i].st, i), image2, vq[i].e2);
      end
    end
    pixel_valid = 1'b0;
    conv_done   = 1'b0;
    vq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pixel_ready"}, 32'(pixel_ready), 32'd0);
    chk({tag, ".image_valid"}, 32'(image_valid), 32'd0);
    chk({tag, ".frame_done"},  32'(frame_done),  32'd0);
    chk({tag, ".window_row"},  32'(window_row),  32'd0);
    chk({tag, ".image0"}, image0, 32'd0);
    chk({tag, ".image1"}, image1, 32'd0);
    chk({tag, ".image2"}, image2, 32'd0);
  endtask

  initial begin
    // Step 1: reset held with random inputs.
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pixel_valid = 1'($urandom);
      pixel_in    = 8'($urandom);
      conv_done   = 1'($urandom);
      @(posedge clk);
      #1;
      chk_all_zero($sformatf("s1.reset%0d", k));
    end
    pixel_valid = 1'b0;
    conv_done   = 1'b0;
    reset       = 1'b1;

    // Step 2: initial three-row load.
    add(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, '0, '0, '0);
    add_row(2, 0, 1'b0, 1'b0, 3'd0, '0, '0, rv(0));
    add_row(2, 1, 1'b0, 1'b0, 3'd0, '0, rv(0), rv(1));
    add_row(2, 2, 1'b0, 1'b1, 3'd0, rv(0), rv(1), rv(2));
    for (int k = 0; k < 3; k++)
      add(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, rv(0), rv(1), rv(2));

    // Step 3: prefetch row 3 while presenting, then advance.
    for (int c = 0; c < W; c++)
      add(3, 1'b1, 8'(8'h30 + c), 1'b0, (c < W-1), 1'b1, 1'b0, 3'd0, 1'b1, rv(0), rv(1), rv(2));
    add(3, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, rv(0), rv(1), rv(2));
    add(3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0);
    add(3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, rv(1), rv(2), rv(3));

    // Step 4: consume with empty fb, conv_done in GAP ignored, slow row 4.
    add(4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, '0, '0, '0);
    add(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, '0, '0, '0);
    add(4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, rv(1), rv(2), rv(3));
    for (int c = 0; c < W; c++) begin
      add(4, 1'b1, 8'(8'h40 + c), 1'b0, (c < W-1), 1'b0, 1'b0, 3'd1, 1'b0, '0, '0, '0);
      if (c < W-1) begin
        add(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, '0, '0, '0);
        add(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, '0, '0, '0);
      end
    end
    add(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, rv(2), rv(3), rv(4));

    // Step 5: last window of the frame, then a full reload of the next frame.
    add(5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, '0, '0, '0);
    add(5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0);
    add_row(5, 0, 1'b0, 1'b0, 3'd0, rv(3), rv(4), rv(0));
    add_row(5, 1, 1'b0, 1'b0, 3'd0, rv(4), rv(0), rv(1));
    add_row(5, 2, 1'b0, 1'b1, 3'd0, rv(0), rv(1), rv(2));
    run_vecs();

    // Step 6: async reset mid-PRESENT with fb half full.
    pixel_valid = 1'b1;
    pixel_in    = 8'h30;
    @(posedge clk);
    #1 pixel_in = 8'h31;
    @(posedge clk);
    #1 pixel_valid = 1'b0;
    chk("s6.pre_reset.image_valid", 32'(image_valid), 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("s6.async");
    @(posedge clk);
    #1 reset = 1'b1;
    add(6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, '0, '0, '0);
    add_row(6, 0, 1'b0, 1'b0, 3'd0, '0, '0, rv(0));
    add_row(6, 1, 1'b0, 1'b0, 3'd0, '0, rv(0), rv(1));
    add_row(6, 2, 1'b0, 1'b1, 3'd0, rv(0), rv(1), rv(2));
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
